// File: rtl/uart_fifo_ctrl_pkg.sv
// Shared constants, state types and helpers for the buffered UART.
package uart_fifo_ctrl_pkg;

    localparam int DIV_W = 16;
    localparam int OSR   = 8;

    localparam int ST_TX_BUSY   = 0;
    localparam int ST_RX_AVAIL  = 1;
    localparam int ST_TX_FULL   = 2;
    localparam int ST_OVERRUN   = 3;
    localparam int ST_FRAME_ERR = 4;
    localparam int ST_OCC_LSB   = 8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    function automatic logic [7:0] sat8(input logic [31:0] v);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/uart_fifo_ctrl_if.sv
// Register bus bundle: data, status and divisor slots.
interface uart_fifo_ctrl_if;

    logic        reg_dat_we;
    logic        reg_dat_re;
    logic [31:0] reg_dat_di;
    logic [31:0] reg_dat_do;
    logic        reg_dat_wait;

    logic        reg_state_we;
    logic        reg_state_re;
    logic [31:0] reg_state_di;
    logic [31:0] reg_state_do;
    logic        reg_state_wait;

    logic        reg_div_we;
    logic        reg_div_re;
    logic [31:0] reg_div_di;
    logic [31:0] reg_div_do;
    logic        reg_div_wait;

    modport master (
        output reg_dat_we, reg_dat_re, reg_dat_di,
        input  reg_dat_do, reg_dat_wait,
        output reg_state_we, reg_state_re, reg_state_di,
        input  reg_state_do, reg_state_wait,
        output reg_div_we, reg_div_re, reg_div_di,
        input  reg_div_do, reg_div_wait
    );

    modport slave (
        input  reg_dat_we, reg_dat_re, reg_dat_di,
        output reg_dat_do, reg_dat_wait,
        input  reg_state_we, reg_state_re, reg_state_di,
        output reg_state_do, reg_state_wait,
        input  reg_div_we, reg_div_re, reg_div_di,
        output reg_div_do, reg_div_wait
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with combinational head and occupancy count.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a full FIFO would refuse
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Buffered UART: TX/RX FIFOs, runtime baud divisor, 8x oversampled RX,
// sticky overrun and framing-error flags.
module uart_fifo_ctrl
    import uart_fifo_ctrl_pkg::*;
#(
    parameter int UART_CLK  = 12000000,
    parameter int BAUD_RATE = 115200,
    parameter int TX_DEPTH  = 16,
    parameter int RX_DEPTH  = 16,
    parameter int STOP_BITS = 1
) (
    input  logic            clk,
    input  logic            reset,
    uart_fifo_ctrl_if.slave bus,
    output logic            ser_tx,
    input  logic            ser_rx
);

    localparam int TCW = $clog2(TX_DEPTH) + 1;
    localparam int RCW = $clog2(RX_DEPTH) + 1;
    localparam logic [DIV_W-1:0] DIV_RST =
        DIV_W'(UART_CLK / (BAUD_RATE * OSR) - 1);
    localparam logic [2:0] PH_LAST  = 3'(OSR - 1);
    localparam logic [2:0] PH_START = 3'(OSR / 2 - 1);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    logic [DIV_W-1:0] div, tick_cnt, tx_pre;
    logic             div_we, tick, rx_tick, tx_bit_end;

    tx_state_t  tx_state;
    logic [7:0] tx_shreg, tx_head;
    logic [2:0] tx_phase, tx_bit;
    logic       tx_stop, tx_pop, tx_full, tx_empty;
    logic [TCW-1:0] tx_count;

    rx_state_t  rx_state;
    logic [7:0] rx_shreg, rx_head;
    logic [2:0] rx_phase, rx_bit;
    logic       rx_s1, rx_s2, rx_prev, rx_fall;
    logic       rx_sample, rx_push, rx_full, rx_empty;
    logic [RCW-1:0] rx_count;

    logic overrun, frame_err, ovr_set, fe_set;
    logic unused_bits;

    assign div_we  = bus.reg_div_we;
    assign tick    = (tick_cnt == div);
    assign rx_tick = tick && !div_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            div      <= DIV_RST;
            tick_cnt <= '0;
        end else if (div_we) begin
            div      <= bus.reg_div_di[DIV_W-1:0];
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        end
    end

    uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset),
        .push(bus.reg_dat_we), .pop(tx_pop),
        .din(bus.reg_dat_di[7:0]), .head(tx_head),
        .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    // TX keeps its own prescaler so every bit is exactly 8*(div+1) clocks
    assign tx_bit_end = !div_we && (tx_pre == div) && (tx_phase == PH_LAST);
    assign tx_pop = !tx_empty && ((tx_state == TX_IDLE) ||
        (tx_state == TX_STOP && tx_bit_end && tx_stop == STOP_LAST));

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            ser_tx   <= 1'b1;
            tx_pre   <= '0;
            tx_phase <= '0;
            tx_bit   <= '0;
            tx_stop  <= 1'b0;
            tx_shreg <= '0;
        end else if (tx_pop) begin
            tx_state <= TX_START;
            ser_tx   <= 1'b0;
            tx_shreg <= tx_head;
            tx_pre   <= '0;
            tx_phase <= '0;
        end else if (div_we) begin
            tx_pre   <= '0;
            tx_phase <= '0;
        end else if (tx_state != TX_IDLE) begin
            if (tx_pre == div) begin
                tx_pre   <= '0;
                tx_phase <= tx_phase + 3'd1;
                if (tx_phase == PH_LAST) begin
                    case (tx_state)
                        TX_START: begin
                            tx_state <= TX_DATA;
                            ser_tx   <= tx_shreg[0];
                            tx_bit   <= '0;
                        end
                        TX_DATA: begin
                            if (tx_bit == 3'd7) begin
                                tx_state <= TX_STOP;
                                ser_tx   <= 1'b1;
                                tx_stop  <= 1'b0;
                            end else begin
                                tx_shreg <= tx_shreg >> 1;
                                ser_tx   <= tx_shreg[1];
                                tx_bit   <= tx_bit + 3'd1;
                            end
                        end
                        TX_STOP: begin
                            if (tx_stop == STOP_LAST) tx_state <= TX_IDLE;
                            else tx_stop <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end else begin
                tx_pre <= tx_pre + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= ser_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall   = rx_prev && !rx_s2;
    assign rx_sample = rx_tick && (rx_phase == PH_LAST) && (rx_state == RX_STOP);
    assign rx_push   = rx_sample && rx_s2;
    assign fe_set    = rx_sample && !rx_s2;
    assign ovr_set   = rx_push && rx_full && !bus.reg_dat_re;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_phase <= '0;
            rx_bit   <= '0;
            rx_shreg <= '0;
        end else begin
            if (div_we) rx_phase <= '0;
            case (rx_state)
                RX_IDLE: if (rx_fall) begin
                    rx_state <= RX_START;
                    rx_phase <= '0;
                end
                RX_START: if (rx_tick) begin
                    if (rx_phase == PH_START) begin
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                        rx_phase <= '0;
                        rx_bit   <= '0;
                    end else begin
                        rx_phase <= rx_phase + 3'd1;
                    end
                end
                RX_DATA: if (rx_tick) begin
                    rx_phase <= rx_phase + 3'd1;
                    if (rx_phase == PH_LAST) begin
                        rx_shreg <= {rx_s2, rx_shreg[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    end
                end
                RX_STOP: if (rx_tick) begin
                    rx_phase <= rx_phase + 3'd1;
                    if (rx_phase == PH_LAST) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset),
        .push(rx_push), .pop(bus.reg_dat_re),
        .din(rx_shreg), .head(rx_head),
        .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    // Set beats a same-cycle software clear
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= ovr_set ||
                (overrun && !(bus.reg_state_we && bus.reg_state_di[ST_OVERRUN]));
            frame_err <= fe_set ||
                (frame_err && !(bus.reg_state_we && bus.reg_state_di[ST_FRAME_ERR]));
        end
    end

    always_comb begin
        bus.reg_state_do = '0;
        bus.reg_state_do[ST_TX_BUSY]   = !tx_empty || (tx_state != TX_IDLE);
        bus.reg_state_do[ST_RX_AVAIL]  = !rx_empty;
        bus.reg_state_do[ST_TX_FULL]   = tx_full;
        bus.reg_state_do[ST_OVERRUN]   = overrun;
        bus.reg_state_do[ST_FRAME_ERR] = frame_err;
        bus.reg_state_do[ST_OCC_LSB +: 8] = sat8(32'(rx_count));
    end

    assign bus.reg_dat_do   = rx_empty ? 32'd0 : {23'd0, 1'b1, rx_head};
    assign bus.reg_div_do   = 32'(div);
    assign bus.reg_dat_wait   = bus.reg_dat_we | bus.reg_dat_re;
    assign bus.reg_state_wait = bus.reg_state_we | bus.reg_state_re;
    assign bus.reg_div_wait   = bus.reg_div_we | bus.reg_div_re;

    assign unused_bits = ^{bus.reg_dat_di[31:8], bus.reg_state_di[31:5],
                           bus.reg_state_di[2:0], bus.reg_div_di[31:16], tx_count};

endmodule
